packet_out_buffer: RTL

//  Store-and-forward buffer directly downstream of the header-stripping packet parser.

---
 rtl/packet_out_buffer.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/packet_out_buffer.sv
// Store-and-forward packet buffer with whole-packet drop and ready/valid output.
// Optional drop counter port enabled by defining PACKET_OUT_BUFFER_DROP_CNT_EN.
//
// state | meaning
// IDLE  | waiting for a sop word
// WRITE | storing an accepted packet, not yet committed
// DROP  | discarding words of a rejected packet until eop
module packet_out_buffer #(
  parameter int WIDTH_DATA_BYTES  = 8,
  parameter int WIDTH_HDR_A_BYTES = 6,
  parameter int WIDTH_HDR_B_BYTES = 4,
  parameter int DEPTH_WORDS       = 16,
  parameter int DEPTH_PKTS        = 4
) (
  input  logic                            clk_host,
  input  logic                            rst_n,
  input  logic                            bus_in_valid,
  input  logic                            bus_in_sop,
  input  logic                            bus_in_eop,
  input  logic [WIDTH_DATA_BYTES-1:0]     bus_in_byteen,
  input  logic [WIDTH_DATA_BYTES*8-1:0]   bus_in_data,
  input  logic [WIDTH_HDR_A_BYTES*8-1:0]  headerA,
  input  logic [WIDTH_HDR_B_BYTES*8-1:0]  headerB,
  input  logic                            bus_out_ready,
  output logic                            bus_out_valid,
  output logic                            bus_out_sop,
  output logic                            bus_out_eop,
  output logic [WIDTH_DATA_BYTES-1:0]     bus_out_byteen,
  output logic [WIDTH_DATA_BYTES*8-1:0]   bus_out_data,
  output logic [WIDTH_HDR_A_BYTES*8-1:0]  bus_out_headerA,
  output logic [WIDTH_HDR_B_BYTES*8-1:0]  bus_out_headerB
`ifdef PACKET_OUT_BUFFER_DROP_CNT_EN
  ,
  output logic [15:0]                     drop_cnt
`endif
);

  localparam int WDB = WIDTH_DATA_BYTES;
  localparam int DW  = WIDTH_DATA_BYTES * 8;
  localparam int HAW = WIDTH_HDR_A_BYTES * 8;
  localparam int HBW = WIDTH_HDR_B_BYTES * 8;
  localparam int AW  = $clog2(DEPTH_WORDS);
  localparam int PW  = $clog2(DEPTH_PKTS);
  localparam logic [AW:0] WPTR_ONE  = 1;
  localparam logic [AW:0] WPTR_FULL = (AW+1)'(DEPTH_WORDS);
  localparam logic [PW:0] PPTR_FULL = (PW+1)'(DEPTH_PKTS);

  typedef struct packed {
    logic           sop;
    logic           eop;
    logic [WDB-1:0] byteen;
    logic [DW-1:0]  data;
  } word_t;

  typedef enum logic [1:0] {IDLE, WRITE, DROP} wr_state_e;

  word_t              mem_q [DEPTH_WORDS];
  logic [HAW+HBW-1:0] hdr_q [DEPTH_PKTS];

  wr_state_e   state_q, state_d;
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] wr_start_q, wr_start_d;
  logic [AW:0] cmt_ptr_q, cmt_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0] hwr_ptr_q, hwr_ptr_d;
  logic [PW:0] hrd_ptr_q, hrd_ptr_d;

  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic          hdr_push;
  logic [1:0]    drop_add;
  word_t         in_word;
  word_t         rd_word;
  logic [HAW+HBW-1:0] hdr_head;
  logic [AW:0]   used_cmt;
  logic [AW:0]   used_all;
  logic          hdr_full;
  logic          out_valid;
  logic          rd_fire;

  assign in_word  = '{sop: bus_in_sop, eop: bus_in_eop, byteen: bus_in_byteen, data: bus_in_data};
  assign used_cmt = cmt_ptr_q - rd_ptr_q;
  assign used_all = wr_ptr_q - rd_ptr_q;
  assign hdr_full = (hwr_ptr_q - hrd_ptr_q) == PPTR_FULL;

  // A sop always restarts from the committed pointer, discarding any uncommitted words.
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    wr_start_d = wr_start_q;
    cmt_ptr_d  = cmt_ptr_q;
    mem_we     = 1'b0;
    mem_waddr  = wr_ptr_q[AW-1:0];
    hdr_push   = 1'b0;
    drop_add   = 2'd0;
    if (bus_in_valid) begin
      if (bus_in_sop) begin
        wr_ptr_d = cmt_ptr_q;
        if (state_q == WRITE) drop_add = 2'd1;
        if (hdr_full || (used_cmt == WPTR_FULL)) begin
          drop_add = drop_add + 2'd1;
          state_d  = bus_in_eop ? IDLE : DROP;
        end else begin
          mem_we     = 1'b1;
          mem_waddr  = cmt_ptr_q[AW-1:0];
          wr_start_d = cmt_ptr_q;
          wr_ptr_d   = cmt_ptr_q + WPTR_ONE;
          if (bus_in_eop) begin
            cmt_ptr_d = cmt_ptr_q + WPTR_ONE;
            hdr_push  = 1'b1;
            state_d   = IDLE;
          end else begin
            state_d = WRITE;
          end
        end
      end else if (state_q == WRITE) begin
        if (used_all == WPTR_FULL) begin
          wr_ptr_d = wr_start_q;
          drop_add = 2'd1;
          state_d  = bus_in_eop ? IDLE : DROP;
        end else begin
          mem_we   = 1'b1;
          wr_ptr_d = wr_ptr_q + WPTR_ONE;
          if (bus_in_eop) begin
            cmt_ptr_d = wr_ptr_q + WPTR_ONE;
            hdr_push  = 1'b1;
            state_d   = IDLE;
          end
        end
      end else if ((state_q == DROP) && bus_in_eop) begin
        state_d = IDLE;
      end
    end
  end

  assign rd_word   = mem_q[rd_ptr_q[AW-1:0]];
  assign hdr_head  = hdr_q[hrd_ptr_q[PW-1:0]];
  assign out_valid = used_cmt != '0;
  assign rd_fire   = out_valid && bus_out_ready;

  always_comb begin
    rd_ptr_d  = rd_ptr_q + {{AW{1'b0}}, rd_fire};
    hrd_ptr_d = hrd_ptr_q + {{PW{1'b0}}, rd_fire && rd_word.eop};
    hwr_ptr_d = hwr_ptr_q + {{PW{1'b0}}, hdr_push};
  end

  always_ff @(posedge clk_host or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      wr_start_q <= '0;
      cmt_ptr_q  <= '0;
      rd_ptr_q   <= '0;
      hwr_ptr_q  <= '0;
      hrd_ptr_q  <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      wr_start_q <= wr_start_d;
      cmt_ptr_q  <= cmt_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      hwr_ptr_q  <= hwr_ptr_d;
      hrd_ptr_q  <= hrd_ptr_d;
    end
  end

  // Storage needs no reset: nothing is visible until a pointer says it is committed.
  always_ff @(posedge clk_host) begin
    if (mem_we) mem_q[mem_waddr] <= in_word;
    if (hdr_push) hdr_q[hwr_ptr_q[PW-1:0]] <= {headerA, headerB};
  end

  assign bus_out_valid   = out_valid;
  assign bus_out_sop     = out_valid & rd_word.sop;
  assign bus_out_eop     = out_valid & rd_word.eop;
  assign bus_out_byteen  = out_valid ? rd_word.byteen : '0;
  assign bus_out_data    = out_valid ? rd_word.data : '0;
  assign bus_out_headerA = out_valid ? hdr_head[HAW+HBW-1:HBW] : '0;
  assign bus_out_headerB = out_valid ? hdr_head[HBW-1:0] : '0;

`ifdef PACKET_OUT_BUFFER_DROP_CNT_EN
  logic [15:0] drop_cnt_q;
  logic [16:0] drop_sum;

  assign drop_sum = {1'b0, drop_cnt_q} + {15'd0, drop_add};

  always_ff @(posedge clk_host or negedge rst_n) begin
    if (!rst_n) drop_cnt_q <= '0;
    else        drop_cnt_q <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end

  assign drop_cnt = drop_cnt_q;
`else
  logic unused_drop;
  assign unused_drop = ^drop_add;
`endif

endmodule
